alarm_sequencer: RTL and testbench



---
 rtl/alarm_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: supervisory front-end for the alarm FSM.
// Turns raw sensor samples into debounced, hysteretic aviso/alarma/vent
// requests, runs the siren cadence and holds the fan on for a minimum time.
module alarm_sequencer #(
  parameter int W          = 8,
  parameter int WARN_TH    = 100,
  parameter int ALARM_TH   = 180,
  parameter int HYST       = 10,
  parameter int DEB        = 4,
  parameter int FAN_MIN    = 16,
  parameter int SIREN_HALF = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         EN,
  input  logic [W-1:0] sensor,
  input  logic         sample_valid,
  input  logic         ack,
  output logic         aviso,
  output logic         alarma,
  output logic         vent,
  output logic         fan_on,
  output logic         siren,
  output logic [2:0]   st
);

  // Every counter shares one width, large enough for the biggest limit.
  localparam int CMAX_A = (DEB > FAN_MIN) ? DEB : FAN_MIN;
  localparam int CMAX   = (CMAX_A > 2 * SIREN_HALF) ? CMAX_A : 2 * SIREN_HALF;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DEB_C        = CW'(DEB);
  localparam logic [CW-1:0] FAN_LAST     = CW'(FAN_MIN - 1);
  localparam logic [CW-1:0] SIREN_HALF_C = CW'(SIREN_HALF);
  localparam logic [CW-1:0] SIREN_LAST   = CW'(2 * SIREN_HALF - 1);

  // Entry thresholds and the lower release thresholds (hysteresis band).
  localparam logic [W-1:0] WARN_C  = W'(WARN_TH);
  localparam logic [W-1:0] ALARM_C = W'(ALARM_TH);
  localparam logic [W-1:0] WREL_C  = W'(WARN_TH - HYST);
  localparam logic [W-1:0] AREL_C  = W'(ALARM_TH - HYST);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MONITOR  = 3'd1,
    WARN     = 3'd2,
    ALARM    = 3'd3,
    VENT     = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] deb_cnt, rel_cnt, fan_tmr, siren_cnt;
  logic [CW-1:0] nxt_deb, nxt_rel, nxt_fan, nxt_siren;
  logic [CW-1:0] deb_inc, rel_inc, fan_inc, siren_step;
  logic          warn_hit, alarm_hit, below_wrel, below_arel;

  // Saturating increment so no counter can ever wrap back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic [CW-1:0] lim);
    return (v >= lim) ? lim : v + CW'(1);
  endfunction

  assign warn_hit   = (sensor >= WARN_C);
  assign alarm_hit  = (sensor >= ALARM_C);
  assign below_wrel = (sensor < WREL_C);
  assign below_arel = (sensor < AREL_C);

  assign deb_inc    = sat_inc(deb_cnt, DEB_C);
  assign rel_inc    = sat_inc(rel_cnt, DEB_C);
  assign fan_inc    = sat_inc(fan_tmr, FAN_LAST);
  assign siren_step = (siren_cnt >= SIREN_LAST) ? '0 : siren_cnt + CW'(1);

  // Next-state and next-counter logic; a state change wipes every counter.
  always_comb begin
    nxt_state = state;
    nxt_deb   = deb_cnt;
    nxt_rel   = rel_cnt;
    nxt_fan   = fan_tmr;
    nxt_siren = siren_cnt;

    if (!EN) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = MONITOR;
        end

        MONITOR: begin
          if (sample_valid) begin
            if (warn_hit) begin
              nxt_deb = deb_inc;
              if (deb_inc >= DEB_C) nxt_state = WARN;
            end else begin
              nxt_deb = '0;
            end
          end
        end

        // deb_cnt tracks the alarm path, rel_cnt the release path.
        WARN: begin
          if (sample_valid) begin
            if (alarm_hit) begin
              nxt_deb = deb_inc;
              nxt_rel = '0;
              if (deb_inc >= DEB_C) nxt_state = ALARM;
            end else if (below_wrel) begin
              nxt_rel = rel_inc;
              nxt_deb = '0;
              if (rel_inc >= DEB_C) nxt_state = MONITOR;
            end else begin
              nxt_deb = '0;
              nxt_rel = '0;
            end
          end
        end

        // Only an operator acknowledge leaves ALARM; samples are ignored.
        ALARM: begin
          nxt_siren = siren_step;
          if (ack) nxt_state = VENT;
        end

        // Leave once both the fan minimum and the debounced release are met.
        VENT: begin
          nxt_siren = siren_step;
          nxt_fan   = fan_inc;
          if (sample_valid) begin
            nxt_deb = below_arel ? deb_inc : '0;
          end
          if ((nxt_deb >= DEB_C) && (fan_tmr == FAN_LAST)) nxt_state = COOLDOWN;
        end

        // A single high sample re-arms the alarm before the timer runs out.
        COOLDOWN: begin
          nxt_fan = fan_inc;
          if (sample_valid && alarm_hit) begin
            nxt_state = ALARM;
          end else if (fan_tmr == FAN_LAST) begin
            nxt_state = MONITOR;
          end
        end

        default: begin
          nxt_state = IDLE;
        end
      endcase
    end

    if (nxt_state != state) begin
      nxt_deb   = '0;
      nxt_rel   = '0;
      nxt_fan   = '0;
      nxt_siren = '0;
    end
  end

  // State, counters and outputs; outputs are decoded from the upcoming state
  // so they line up with the new state right after the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      fan_tmr   <= '0;
      siren_cnt <= '0;
      aviso     <= 1'b0;
      alarma    <= 1'b0;
      vent      <= 1'b0;
      fan_on    <= 1'b0;
      siren     <= 1'b0;
    end else begin
      state     <= nxt_state;
      deb_cnt   <= nxt_deb;
      rel_cnt   <= nxt_rel;
      fan_tmr   <= nxt_fan;
      siren_cnt <= nxt_siren;
      aviso     <= (nxt_state == WARN);
      alarma    <= (nxt_state == ALARM) || (nxt_state == VENT);
      vent      <= (nxt_state == VENT);
      fan_on    <= (nxt_state == VENT) || (nxt_state == COOLDOWN);
      siren     <= ((nxt_state == ALARM) || (nxt_state == VENT)) &&
                   (nxt_siren < SIREN_HALF_C);
    end
  end

  assign st = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scoreboard bench for alarm_sequencer. A cycle model
// pushes the expected output vector each time stimulus is driven; the value
// is popped and compared once the DUT has clocked that stimulus in.
module tb_alarm_sequencer;

  localparam int WARN_TH  = 100;
  localparam int ALARM_TH = 180;
  localparam int WREL     = 90;
  localparam int AREL     = 170;
  localparam int DEB      = 4;
  localparam int FAN_MIN  = 16;
  localparam int HALF     = 4;

  logic       clk = 1'b0;
  logic       reset, EN, sample_valid, ack;
  logic [7:0] sensor;
  logic       aviso, alarma, vent, fan_on, siren;
  logic [2:0] st;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];

  // Model state: current state, cycles spent in it, and two sample streaks.
  int m_state, m_time, m_up, m_dn;

  alarm_sequencer #(
    .W(8), .WARN_TH(WARN_TH), .ALARM_TH(ALARM_TH), .HYST(10),
    .DEB(DEB), .FAN_MIN(FAN_MIN), .SIREN_HALF(HALF)
  ) dut (
    .clk(clk), .reset(reset), .EN(EN), .sensor(sensor),
    .sample_valid(sample_valid), .ack(ack),
    .aviso(aviso), .alarma(alarma), .vent(vent), .fan_on(fan_on),
    .siren(siren), .st(st)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs the outputs the model expects: {st, aviso, alarma, vent, fan_on, siren}.
  function automatic logic [7:0] modelOutputs(input int s, input int t);
    logic [2:0] code;
    logic       sir;
    code = 3'(s);
    sir  = ((s == 3) || (s == 4)) && ((t % (2 * HALF)) < HALF);
    return {code, (s == 2), (s == 3 || s == 4), (s == 4), (s == 4 || s == 5), sir};
  endfunction

  // Drives one cycle of stimulus, advances the model, then checks the DUT.
  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [7:0] s, input logic a);
    int ns;
    logic [7:0] got, exp;
    @(negedge clk);
    reset = r; EN = e; sample_valid = v; sensor = s; ack = a;
    if (r) begin
      m_state = 0; m_time = 0; m_up = 0; m_dn = 0;
      exp_q.push_back(8'h00);
    end else begin
      ns = m_state;
      if (!e) ns = 0;
      else begin
        case (m_state)
          0: ns = 1;
          1: if (v) begin
               if (s >= WARN_TH) begin m_up++; if (m_up >= DEB) ns = 2; end
               else m_up = 0;
             end
          2: if (v) begin
               if (s >= ALARM_TH) begin m_up++; m_dn = 0; if (m_up >= DEB) ns = 3; end
               else if (s < WREL) begin m_dn++; m_up = 0; if (m_dn >= DEB) ns = 1; end
               else begin m_up = 0; m_dn = 0; end
             end
          3: if (a) ns = 4;
          4: begin
               if (v) m_dn = (s < AREL) ? m_dn + 1 : 0;
               if (m_dn >= DEB && m_time >= FAN_MIN - 1) ns = 5;
             end
          5: if (v && s >= ALARM_TH) ns = 3;
             else if (m_time >= FAN_MIN - 1) ns = 1;
          default: ns = 0;
        endcase
      end
      if (ns != m_state) begin m_time = 0; m_up = 0; m_dn = 0; end
      else m_time++;
      m_state = ns;
      exp_q.push_back(modelOutputs(m_state, m_time));
    end
    @(posedge clk);
    #1;
    got = {st, aviso, alarma, vent, fan_on, siren};
    exp = exp_q.pop_front();
    cyc++;
    checkOutput($sformatf("cycle%0d", cyc), got, exp);
  endtask

  task automatic sample(input logic [7:0] s);
    applyStimulus(1'b0, 1'b1, 1'b1, s, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  // Directed sequence through every state, then a randomised soak.
  initial begin
    logic [7:0] picks[10];
    logic [7:0] s;
    picks = '{8'd0, 8'd89, 8'd90, 8'd99, 8'd100, 8'd169, 8'd170, 8'd179, 8'd180, 8'd255};
    reset = 1'b1; EN = 1'b0; sample_valid = 1'b0; sensor = '0; ack = 1'b0;
    m_state = 0; m_time = 0; m_up = 0; m_dn = 0;

    applyStimulus(1'b1, 1'b1, 1'b1, 8'd200, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd200, 1'b0);
    checkOutput("reset_outputs", {st, aviso, alarma, vent, fan_on, siren}, 8'h00);

    idle(1);
    checkOutput("monitor_entry", {5'd0, st}, 8'd1);
    sample(200); idle(1); sample(200); idle(2); sample(200);
    checkOutput("no_warn_yet", {5'd0, st}, 8'd1);
    sample(200);
    checkOutput("warn_entry", {5'd0, st}, 8'd2);

    for (int i = 0; i < 4; i++) sample(50);
    checkOutput("warn_release", {5'd0, st}, 8'd1);
    sample(120); sample(120); sample(50);
    sample(120); sample(120); sample(120);
    checkOutput("debounce_cleared", {5'd0, st}, 8'd1);
    sample(120);
    checkOutput("warn_aviso", {6'd0, aviso, st == 3'd2}, 8'h03);

    sample(180); sample(180); sample(179); sample(90);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) sample(185);
    checkOutput("alarm_entry", {5'd0, st}, 8'd3);
    for (int i = 0; i < 10; i++) sample(50);
    checkOutput("alarm_holds", {5'd0, st}, 8'd3);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    checkOutput("vent_entry", {5'd0, vent, fan_on, st == 3'd4}, 8'h07);
    idle(1);
    for (int i = 0; i < 22; i++) sample(100);
    checkOutput("cooldown_fan", {5'd0, st}, 8'd5);
    idle(18);
    checkOutput("back_to_monitor", {5'd0, st}, 8'd1);

    for (int i = 0; i < 4; i++) sample(150);
    for (int i = 0; i < 4; i++) sample(200);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    idle(18);
    sample(170);
    for (int i = 0; i < 4; i++) sample(169);
    checkOutput("cooldown_by_deb", {5'd0, st}, 8'd5);
    idle(3);
    sample(190);
    checkOutput("rearm_alarm", {5'd0, alarma, fan_on, st == 3'd3}, 8'h05);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd200, 1'b0);
    checkOutput("disable_idle", {st, aviso, alarma, vent, fan_on, siren}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    idle(1);
    checkOutput("reenable", {5'd0, st}, 8'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                      : picks[$urandom_range(0, 9)];
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 59) != 0,
                    1'($urandom_range(0, 1)), s, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
